// File: rtl/vma_cycle_seq_if.sv
// Signal bundle between the microcode/ifetch requesters, the VMA/map/bus
// datapath and the VMA cycle sequencer.
// master: requester/datapath side (drives requests and map/bus status).
// slave : the sequencer itself.
interface vma_cycle_seq_if;
    logic mem_req;
    logic mem_wr;
    logic ifetch_req;
    logic map_valid;
    logic map_wr_ok;
    logic bus_ack;
    logic vmasel;
    logic vma_load;
    logic memprepare;
    logic bus_req;
    logic bus_wr;
    logic uc_gnt;
    logic if_gnt;
    logic mem_busy;
    logic mem_done;
    logic pgf_rd;
    logic pgf_wr;
    logic bus_timeout;

    modport master (
        output mem_req, mem_wr, ifetch_req, map_valid, map_wr_ok, bus_ack,
        input  vmasel, vma_load, memprepare, bus_req, bus_wr, uc_gnt, if_gnt,
               mem_busy, mem_done, pgf_rd, pgf_wr, bus_timeout
    );

    modport slave (
        input  mem_req, mem_wr, ifetch_req, map_valid, map_wr_ok, bus_ack,
        output vmasel, vma_load, memprepare, bus_req, bus_wr, uc_gnt, if_gnt,
               mem_busy, mem_done, pgf_rd, pgf_wr, bus_timeout
    );
endinterface

// File: rtl/vma_cycle_seq.sv
// VMA cycle sequencer: arbitrates microcode vs instruction-fetch memory
// requests, steers the VMA source mux, holds the map lookup for MAP_LAT
// cycles, checks the map result and runs the bus cycle.
// Optional bus timeout abort is enabled by defining VMA_SEQ_TIMEOUT_EN.
module vma_cycle_seq #(
    parameter int MAP_LAT     = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    vma_cycle_seq_if.slave  bus
);

    localparam int MW = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;
    localparam logic [MW-1:0] MAP_LAST = MW'(MAP_LAT - 1);

    // Reject impossible configurations at elaboration time.
    if (MAP_LAT < 1 || TIMEOUT_CYC >= (1 << TO_W)) begin : g_cfg_err
        $error("vma_cycle_seq: MAP_LAT must be >= 1 and TIMEOUT_CYC < 2**TO_W");
    end

    typedef enum logic [1:0] {IDLE, LOAD, MAP, BUS} state_t;

    state_t        state, state_nxt;
    logic          src_uc, src_uc_nxt;
    logic          wr, wr_nxt;
    logic [MW-1:0] map_cnt, map_cnt_nxt;
    logic          uc_gnt_q, uc_gnt_nxt;
    logic          if_gnt_q, if_gnt_nxt;
    logic          done_q, done_nxt;
    logic          pgf_rd_q, pgf_rd_nxt;
    logic          pgf_wr_q, pgf_wr_nxt;
`ifdef VMA_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            timeout_q, timeout_nxt;
`endif

    // Next-state, request latching and next values of the one-cycle pulses.
    always_comb begin
        state_nxt   = state;
        src_uc_nxt  = src_uc;
        wr_nxt      = wr;
        map_cnt_nxt = '0;
        uc_gnt_nxt  = 1'b0;
        if_gnt_nxt  = 1'b0;
        done_nxt    = 1'b0;
        pgf_rd_nxt  = 1'b0;
        pgf_wr_nxt  = 1'b0;
`ifdef VMA_SEQ_TIMEOUT_EN
        to_cnt_nxt  = '0;
        timeout_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    src_uc_nxt = 1'b1;
                    wr_nxt     = bus.mem_wr;
                    uc_gnt_nxt = 1'b1;
                    state_nxt  = LOAD;
                end else if (bus.ifetch_req) begin
                    src_uc_nxt = 1'b0;
                    wr_nxt     = 1'b0;
                    if_gnt_nxt = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                state_nxt = MAP;
            end
            MAP: begin
                if (map_cnt == MAP_LAST) begin
                    if (!bus.map_valid) begin
                        pgf_rd_nxt = !wr;
                        pgf_wr_nxt = wr;
                        state_nxt  = IDLE;
                    end else if (wr && !bus.map_wr_ok) begin
                        pgf_wr_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt  = BUS;
                    end
                end else begin
                    map_cnt_nxt = map_cnt + 1'b1;
                end
            end
            BUS: begin
                if (bus.bus_ack) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef VMA_SEQ_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYC)) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latched request attributes, counters and registered pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            src_uc    <= 1'b0;
            wr        <= 1'b0;
            map_cnt   <= '0;
            uc_gnt_q  <= 1'b0;
            if_gnt_q  <= 1'b0;
            done_q    <= 1'b0;
            pgf_rd_q  <= 1'b0;
            pgf_wr_q  <= 1'b0;
`ifdef VMA_SEQ_TIMEOUT_EN
            to_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            src_uc    <= src_uc_nxt;
            wr        <= wr_nxt;
            map_cnt   <= map_cnt_nxt;
            uc_gnt_q  <= uc_gnt_nxt;
            if_gnt_q  <= if_gnt_nxt;
            done_q    <= done_nxt;
            pgf_rd_q  <= pgf_rd_nxt;
            pgf_wr_q  <= pgf_wr_nxt;
`ifdef VMA_SEQ_TIMEOUT_EN
            to_cnt    <= to_cnt_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    assign bus.vma_load   = (state == LOAD);
    assign bus.vmasel     = ((state == LOAD) || (state == MAP)) && src_uc;
    assign bus.memprepare = (state == MAP);
    assign bus.bus_req    = (state == BUS);
    assign bus.bus_wr     = (state == BUS) && wr;
    assign bus.mem_busy   = (state != IDLE);
    assign bus.uc_gnt     = uc_gnt_q;
    assign bus.if_gnt     = if_gnt_q;
    assign bus.mem_done   = done_q;
    assign bus.pgf_rd     = pgf_rd_q;
    assign bus.pgf_wr     = pgf_wr_q;
`ifdef VMA_SEQ_TIMEOUT_EN
    assign bus.bus_timeout = timeout_q;
`else
    assign bus.bus_timeout = 1'b0;
`endif

endmodule
